load_store_unit: RTL
====================

Name: load_store_unit

Overview:
Memory stage between the ALU and the data memory. It takes the ALU address result and the rs2 store data, runs a request/grant/response handshake with the data memory, and aligns and sign-extends load data for the writeback mux. It produces `dmem_valid`, which the `pc` block uses to hold the fetch address while a data access is in flight.

Parameters:
- TIMEOUT, 255, maximum cycles spent in REQ+WAIT before the access is aborted with error; valid range 1..255.
- CNT_W, 8, width of the timeout counter; must satisfy TIMEOUT < 2^CNT_W.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- load  input  1  current instruction is a load; held until dmem_valid.
- store  input  1  current instruction is a store; held until dmem_valid.
- funct3  input  3  access type: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- addr  input  32  effective byte address from the ALU.
- wdata  input  32  store data (rs2).
- dmem_valid  output  1  one-cycle pulse: access complete.
- load_data  output  32  aligned, extended load result.
- err  output  1  one-cycle pulse with dmem_valid: access faulted.
- mem_req  output  1  bus request.
- mem_we  output  1  1 = write.
- mem_addr  output  32  word address, {addr[31:2], 2'b00}.
- mem_wstrb  output  4  byte write enables.
- mem_wdata  output  32  store data shifted into byte lanes.
- mem_gnt  input  1  bus accepted the request this cycle.
- mem_rvalid  input  1  read data valid.
- mem_rdata  input  32  read data word.

Behaviour:
- States: IDLE, REQ, WAIT, DONE. Reset state is IDLE. On reset, all outputs are 0 and load_data is 0x0.
- IDLE:
  - If load or store is high, latch addr, funct3, wdata and the direction, clear the counter, and go to REQ.
  - If load and store are both high, treat the access as a load.
- REQ:
  - mem_req, mem_we, mem_addr, mem_wstrb and mem_wdata are driven from the latched values and stay stable until mem_gnt.
  - On mem_gnt, a load goes to WAIT and a store goes to DONE.
- WAIT:
  - On mem_rvalid, capture the extracted data into load_data and go to DONE.
  - If mem_rvalid arrives in the same cycle as mem_gnt, REQ moves directly to DONE with the data captured.
- DONE: dmem_valid=1 for exactly one cycle, then return to IDLE. The request is never re-issued from the same instruction because `pc` advances on this edge.
- Minimum latency: request seen in cycle 0, mem_req high in cycle 1 with gnt and rvalid both in cycle 1, dmem_valid in cycle 2.
- Timeout:
  - The counter increments every cycle in REQ and WAIT.
  - When it reaches TIMEOUT, go to DONE with err=1 and load_data=0. mem_req drops immediately.
- Store lanes:
  - B: wstrb = 0001 << addr[1:0], data byte replicated ×4.
  - H: wstrb = 0011 << {addr[1],0}, data half replicated ×2.
  - W: wstrb = 1111.
- Load extract:
  - Select the byte or half by addr[1:0].
  - B and H sign-extend; BU and HU zero-extend; W passes the word through.
- Illegal funct3: no bus request; go straight to DONE with err=1 and load_data=0.
- load_data holds its value until the next load completes.
- Reset asserted mid-access (REQ or WAIT): return to IDLE next cycle with mem_req=0. A late mem_rvalid arriving while in IDLE is ignored.
- The `pc` stall condition is `(load|store) && !dmem_valid`.

Optional Feature:
MISALIGN_TRAP_EN
- Defined:
  - A halfword access with addr[0]=1, or a word access with addr[1:0]≠00, issues no mem_req.
  - The FSM goes IDLE→DONE with err=1 and load_data=0.
- Undefined:
  - The low offset bits are forced to natural alignment: H uses addr[1] only, W uses offset 00.
  - No error is raised.

Test Plan:
- LB, addr=0x1003, gnt+rvalid in the same cycle, rdata=0x80FF1234 → mem_addr=0x1000, load_data=0xFFFFFF80, dmem_valid exactly 2 cycles after load rises.
- LHU, addr=0x2002, gnt delayed 3 cycles, rdata=0xBEEF0000 → mem_req stable for 4 cycles, load_data=0x0000BEEF, err=0.
- SH, addr=0x3002, wdata=0x1234ABCD → mem_we=1, wstrb=1100, mem_wdata=0xABCDABCD, mem_addr=0x3000, dmem_valid one cycle after gnt.
- LW with gnt never asserted, TIMEOUT=4 → mem_req drops after 4 REQ cycles, dmem_valid=1 with err=1, load_data=0.
- LW, addr=0x1001 with MISALIGN_TRAP_EN → mem_req never rises, err=1 on dmem_valid. Without the macro → mem_addr=0x1000 and the full word is returned.
- rst pulsed while in WAIT, followed by a late mem_rvalid → FSM in IDLE, all outputs 0, load_data unchanged at 0, no dmem_valid.

Source files
------------

// File: rtl/load_store_unit.sv
// Purpose : memory stage; runs req/gnt/rvalid handshake to data memory, lane-aligns stores, extracts/extends loads.
// Latency : 2 cycles minimum from load/store to dmem_valid (gnt+rvalid in the first REQ cycle); aborts after TIMEOUT cycles.
// Backpressure: mem_req and its payload hold stable until mem_gnt; the caller holds load/store until dmem_valid.
//
// Ports: clk/rst (sync, active-high); load/store/funct3/addr/wdata from the ALU stage;
//        dmem_valid/err/load_data to writeback; mem_req/we/addr/wstrb/wdata out, mem_gnt/rvalid/rdata in.
// Optional: define MISALIGN_TRAP_EN to fault misaligned H/W accesses instead of force-aligning them.
module load_store_unit #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        dmem_valid,
    output logic [31:0] load_data,
    output logic        err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

    state_e             state_q, state_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [31:0]        load_data_q, load_data_d;
    logic [2:0]         funct3_q, funct3_d;
    logic               is_load_q, is_load_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               f3_legal;
    logic               misaligned;
    logic               timed_out;
    logic [1:0]         off;
    logic [3:0]         strb;
    logic [31:0]        lane_wdata;
    logic [31:0]        rdata_sh;
    logic [31:0]        rdata_ext;

    // Decode of the incoming request, evaluated only while IDLE.
    assign f3_legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                      (funct3 == 3'b100) || (funct3 == 3'b101);
`ifdef MISALIGN_TRAP_EN
    assign misaligned = ((funct3[1:0] == 2'b01) && addr[0]) ||
                        ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    // The final REQ/WAIT cycle is the one where cnt_q reaches TIMEOUT-1.
    assign timed_out = (cnt_q >= CNT_W'(TIMEOUT - 1));

    // Natural-alignment offset: the low bits a given size cannot use are dropped.
    always_comb begin
        off        = 2'b00;
        strb       = 4'b1111;
        lane_wdata = wdata_q;
        case (funct3_q[1:0])
            2'b00: begin
                off        = addr_q[1:0];
                strb       = 4'b0001 << addr_q[1:0];
                lane_wdata = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                off        = {addr_q[1], 1'b0};
                strb       = 4'b0011 << {addr_q[1], 1'b0};
                lane_wdata = {2{wdata_q[15:0]}};
            end
            default: ;
        endcase
    end

    // funct3[2] selects zero-extension (BU/HU).
    always_comb begin
        rdata_sh  = mem_rdata >> {off, 3'b000};
        rdata_ext = mem_rdata;
        case (funct3_q[1:0])
            2'b00:   rdata_ext = {{24{~funct3_q[2] & rdata_sh[7]}}, rdata_sh[7:0]};
            2'b01:   rdata_ext = {{16{~funct3_q[2] & rdata_sh[15]}}, rdata_sh[15:0]};
            default: rdata_ext = mem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            load_data_q <= '0;
            funct3_q    <= '0;
            is_load_q   <= 1'b0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            load_data_q <= load_data_d;
            funct3_q    <= funct3_d;
            is_load_q   <= is_load_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        load_data_d = load_data_q;
        funct3_d    = funct3_q;
        is_load_d   = is_load_q;
        err_d       = err_q;
        cnt_d       = cnt_q;
        case (state_q)
            IDLE: begin
                if (load || store) begin
                    addr_d    = addr;
                    funct3_d  = funct3;
                    wdata_d   = wdata;
                    is_load_d = load;   // load wins when both are high
                    cnt_d     = '0;
                    err_d     = 1'b0;
                    if (!f3_legal || misaligned) begin
                        state_d     = DONE;
                        err_d       = 1'b1;
                        load_data_d = '0;
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                cnt_d = cnt_q + 1'b1;
                if (mem_gnt) begin
                    if (!is_load_q) begin
                        state_d = DONE;
                    end else if (mem_rvalid) begin
                        load_data_d = rdata_ext;
                        state_d     = DONE;
                    end else begin
                        state_d = WAIT;
                    end
                end else if (timed_out) begin
                    state_d     = DONE;
                    err_d       = 1'b1;
                    load_data_d = '0;
                end
            end
            WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (mem_rvalid) begin
                    load_data_d = rdata_ext;
                    state_d     = DONE;
                end else if (timed_out) begin
                    state_d     = DONE;
                    err_d       = 1'b1;
                    load_data_d = '0;
                end
            end
            DONE: begin
                state_d = IDLE;
                err_d   = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    // Bus payload is zero outside REQ so idle/reset outputs read as 0.
    assign dmem_valid = (state_q == DONE);
    assign err        = dmem_valid & err_q;
    assign load_data  = load_data_q;
    assign mem_req    = (state_q == REQ);
    assign mem_we     = mem_req & ~is_load_q;
    assign mem_addr   = mem_req ? {addr_q[31:2], 2'b00} : 32'h0;
    assign mem_wstrb  = mem_we ? strb : 4'b0000;
    assign mem_wdata  = mem_we ? lane_wdata : 32'h0;

endmodule
